// File: rtl/conv_fp_kernel_bank.sv
// Pixel-window pipeline stage with a bank of runtime-loadable convolution
// kernels. A kernel is streamed into a shadow buffer one entry per beat,
// then committed into its target bank at the next frame start, so a kernel
// never changes in the middle of a frame.
module conv_fp_kernel_bank #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 5,
  parameter int WINDOW_HEIGHT = 5,
  parameter int NUM_KERNELS   = 4,
  localparam int FP_WIDTH     = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int LINEAR       = WINDOW_WIDTH * WINDOW_HEIGHT,
  localparam int KSEL_W       = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] window_i,
  input  logic [15:0]                                           col_i,
  input  logic [15:0]                                           row_i,
  input  logic                                                  valid_i,
  input  logic [KSEL_W-1:0]                                     kernel_sel_i,
  input  logic                                                  ld_start_i,
  input  logic [KSEL_W-1:0]                                     ld_kernel_i,
  input  logic                                                  ld_valid_i,
  input  logic [FP_WIDTH-1:0]                                   ld_data_i,
  output logic                                                  ld_ready_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] window_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] kernel_o,
  output logic [15:0]                                           col_o,
  output logic [15:0]                                           row_o,
  output logic                                                  valid_o,
  output logic                                                  pending_o
);

  localparam int IDX_W     = (LINEAR > 1) ? $clog2(LINEAR) : 1;
  localparam int BANK_SPAN = 1 << KSEL_W;
  localparam int CENTRE    = (WINDOW_HEIGHT / 2) * WINDOW_WIDTH + WINDOW_WIDTH / 2;

  // 1.0 in the parameterised format: sign 0, exponent = bias, fraction 0.
  localparam logic [FP_WIDTH-1:0] FP_ONE =
    {2'b00, {(EXP_WIDTH - 1){1'b1}}, {FRAC_WIDTH{1'b0}}};

  // Raster-ordered kernel: entry row*WINDOW_WIDTH+col, which matches the
  // bit layout of the [row][col] packed output port.
  typedef logic [LINEAR-1:0][FP_WIDTH-1:0] kernel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } load_state_e;

  function automatic kernel_t identity_kernel();
    kernel_t k;
    k         = '0;
    k[CENTRE] = FP_ONE;
    return k;
  endfunction

  // Marks which encodings of a KSEL_W-bit index name a real bank.
  function automatic logic [BANK_SPAN-1:0] valid_banks();
    logic [BANK_SPAN-1:0] m;
    for (int i = 0; i < BANK_SPAN; i++) m[i] = (i < NUM_KERNELS);
    return m;
  endfunction

  localparam kernel_t              IDENTITY = identity_kernel();
  localparam logic [BANK_SPAN-1:0] BANK_OK  = valid_banks();

  load_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [KSEL_W-1:0]  target_q;
  logic [KSEL_W-1:0]  sel_q;
  kernel_t            shadow_q;
  kernel_t            active_q [NUM_KERNELS];

  logic               frame_start;
  logic               start_load;
  logic               accept_beat;
  logic               commit;
  logic [KSEL_W-1:0]  sel_map;
  logic [KSEL_W-1:0]  target_map;

  assign frame_start = valid_i && (col_i == 16'd0) && (row_i == 16'd0);

  // Out-of-range bank indices fold onto bank 0.
  assign sel_map    = BANK_OK[kernel_sel_i] ? kernel_sel_i : '0;
  assign target_map = BANK_OK[ld_kernel_i]  ? ld_kernel_i  : '0;

  // Selected bank is registered state, so a commit and a selection on the
  // same frame-start edge are both visible on the very next output cycle.
  assign kernel_o = active_q[sel_q];

  // Load FSM state register.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state is updated with <= so every register samples the
    // pre-edge values; blocking = here would create order-dependent races.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Load FSM next-state, handshake outputs and datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    ld_ready_o  = 1'b0;
    pending_o   = 1'b0;
    start_load  = 1'b0;
    accept_beat = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          start_load = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          accept_beat = 1'b1;
          if (idx_q == IDX_W'(LINEAR - 1)) state_d = PENDING;
        end
      end
      PENDING: begin
        pending_o = 1'b1;
        if (frame_start) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-cycle pass-through of the pixel stream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      col_o    <= '0;
      row_o    <= '0;
      window_o <= '0;
    end else begin
      valid_o  <= valid_i;
      col_o    <= col_i;
      row_o    <= row_i;
      window_o <= window_i;
    end
  end

  // Shadow buffer fill, load target and per-frame bank selection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      target_q <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
    end else begin
      if (frame_start) sel_q <= sel_map;
      if (start_load) begin
        target_q <= target_map;
        idx_q    <= '0;
      end
      if (accept_beat) begin
        shadow_q[idx_q] <= ld_data_i;
        idx_q           <= idx_q + IDX_W'(1);
      end
    end
  end

  // Active kernel banks: identity after reset, replaced only by a commit.
  always_ff @(posedge clk_i) begin
    // NOTE: the bank storage is deliberately reset because a defined
    // identity kernel must be available straight out of reset; plain data
    // buffers elsewhere would normally be left unreset.
    if (rst_i) begin
      for (int k = 0; k < NUM_KERNELS; k++) active_q[k] <= IDENTITY;
    end else if (commit) begin
      active_q[target_q] <= shadow_q;
    end
  end

endmodule

// File: tb/tb_conv_fp_kernel_bank.sv
// Randomised bench for conv_fp_kernel_bank. A transaction-level model keeps
// the banks, the shadow kernel and the load progress as plain arrays and
// counters, and predicts every output after each clock edge.
module tb_conv_fp_kernel_bank;

  localparam int EW  = 5;
  localparam int FW  = 10;
  localparam int WW  = 5;
  localparam int WH  = 5;
  localparam int NK  = 3;            // non power of two: index 3 folds to 0
  localparam int FPW = 1 + EW + FW;
  localparam int LIN = WW * WH;
  localparam int KW  = 2;
  localparam int CEN = (WH / 2) * WW + WW / 2;

  logic                            clk = 1'b0;
  logic                            rst_i;
  logic [WH-1:0][WW-1:0][FPW-1:0]  window_i;
  logic [15:0]                     col_i, row_i;
  logic                            valid_i;
  logic [KW-1:0]                   kernel_sel_i;
  logic                            ld_start_i;
  logic [KW-1:0]                   ld_kernel_i;
  logic                            ld_valid_i;
  logic [FPW-1:0]                  ld_data_i;
  logic                            ld_ready_o;
  logic [WH-1:0][WW-1:0][FPW-1:0]  window_o;
  logic [WH-1:0][WW-1:0][FPW-1:0]  kernel_o;
  logic [15:0]                     col_o, row_o;
  logic                            valid_o;
  logic                            pending_o;

  conv_fp_kernel_bank #(
    .EXP_WIDTH    (EW),
    .FRAC_WIDTH   (FW),
    .WINDOW_WIDTH (WW),
    .WINDOW_HEIGHT(WH),
    .NUM_KERNELS  (NK)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .window_i     (window_i),
    .col_i        (col_i),
    .row_i        (row_i),
    .valid_i      (valid_i),
    .kernel_sel_i (kernel_sel_i),
    .ld_start_i   (ld_start_i),
    .ld_kernel_i  (ld_kernel_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .window_o     (window_o),
    .kernel_o     (kernel_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .valid_o      (valid_o),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [FPW-1:0] m_bank [NK][LIN];
  logic [FPW-1:0] m_shadow [LIN];
  int             m_sel;
  int             m_target;
  int             m_count;
  bit             m_loading;
  bit             m_pending;

  logic [LIN*FPW-1:0] id_flat;
  logic [LIN*FPW-1:0] snap;

  function automatic int map_k(input logic [KW-1:0] k);
    return (int'(k) < NK) ? int'(k) : 0;
  endfunction

  function automatic logic [LIN*FPW-1:0] bank_flat(input int b);
    logic [LIN*FPW-1:0] r;
    for (int i = 0; i < LIN; i++) r[i*FPW +: FPW] = m_bank[b][i];
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // clock the DUT and compare every output against the prediction.
  task automatic step();
    bit                 fs;
    logic               e_valid;
    logic [15:0]        e_col, e_row;
    logic [LIN*FPW-1:0] e_win;
    if (rst_i) begin
      for (int b = 0; b < NK; b++)
        for (int i = 0; i < LIN; i++) m_bank[b][i] = (i == CEN) ? 16'h3C00 : 16'h0000;
      for (int i = 0; i < LIN; i++) m_shadow[i] = '0;
      m_sel = 0; m_target = 0; m_count = 0; m_loading = 0; m_pending = 0;
      e_valid = 1'b0; e_col = '0; e_row = '0; e_win = '0;
    end else begin
      fs = valid_i && col_i == 16'd0 && row_i == 16'd0;
      if (m_pending && fs) begin
        for (int i = 0; i < LIN; i++) m_bank[m_target][i] = m_shadow[i];
        m_pending = 0;
      end else if (!m_loading && !m_pending && ld_start_i) begin
        m_loading = 1; m_target = map_k(ld_kernel_i); m_count = 0;
      end else if (m_loading && ld_valid_i) begin
        m_shadow[m_count] = ld_data_i;
        m_count++;
        if (m_count == LIN) begin
          m_loading = 0; m_pending = 1;
        end
      end
      if (fs) m_sel = map_k(kernel_sel_i);
      e_valid = valid_i; e_col = col_i; e_row = row_i; e_win = window_i;
    end
    @(posedge clk);
    #1;
    check("valid_o",    512'(valid_o),    512'(e_valid));
    check("col_o",      512'(col_o),      512'(e_col));
    check("row_o",      512'(row_o),      512'(e_row));
    check("window_o",   512'(window_o),   512'(e_win));
    check("kernel_o",   512'(kernel_o),   512'(bank_flat(m_sel)));
    check("ld_ready_o", 512'(ld_ready_o), 512'(m_loading));
    check("pending_o",  512'(pending_o),  512'(m_pending));
  endtask

  task automatic set_pixel(input bit fs);
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++) window_i[r][c] = FPW'($urandom);
    if (fs) begin
      valid_i = 1'b1; col_i = 16'd0; row_i = 16'd0;
    end else begin
      valid_i = 1'($urandom);
      col_i   = 16'($urandom_range(0, 39));
      row_i   = 16'($urandom_range(0, 29));
      if (col_i == 16'd0 && row_i == 16'd0) row_i = 16'd1;
    end
  endtask

  task automatic cycle(input bit fs);
    set_pixel(fs);
    step();
  endtask

  task automatic start_load(input logic [KW-1:0] k);
    ld_start_i = 1'b1; ld_kernel_i = k;
    cycle(1'b0);
    ld_start_i = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid_i = 1'b1; ld_data_i = FPW'($urandom);
      cycle(1'b0);
    end
    ld_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    id_flat = '0;
    id_flat[CEN*FPW +: FPW] = 16'h3C00;
    rst_i = 1'b1; ld_start_i = 1'b0; ld_kernel_i = '0; ld_valid_i = 1'b0;
    ld_data_i = '0; kernel_sel_i = '0;
    set_pixel(1'b0);

    // Reset state.
    cycle(1'b0);
    rst_i = 1'b0;
    check("rst_valid",  512'(valid_o),  512'(0));
    check("rst_window", 512'(window_o), 512'(0));
    check("rst_kernel", 512'(kernel_o), 512'(id_flat));

    // Identity kernel on the first frame.
    kernel_sel_i = 2'd0;
    cycle(1'b1);
    check("id_centre", 512'(kernel_o[2][2]), 512'(16'h3C00));
    check("id_corner", 512'(kernel_o[0][0]), 512'(16'h0000));

    // Full load of bank 2 with 1.0, committed at the next frame start.
    start_load(2'd2);
    for (int i = 0; i < LIN; i++) begin
      ld_valid_i = 1'b1; ld_data_i = 16'h3C00;
      cycle(1'b0);
    end
    ld_valid_i = 1'b0;
    check("c_pending", 512'(pending_o), 512'(1));
    for (int i = 0; i < 3; i++) cycle(1'b0);
    kernel_sel_i = 2'd2;
    cycle(1'b1);
    check("c_all_one",   512'(kernel_o),  512'({LIN{16'h3C00}}));
    check("c_committed", 512'(pending_o), 512'(0));

    // Gapped beats: only accepted beats advance the fill position.
    start_load(2'd1);
    accepted = 0;
    for (int k = 0; k < 300 && accepted < LIN; k++) begin
      ld_valid_i = 1'($urandom); ld_data_i = FPW'($urandom);
      if (ld_valid_i) accepted++;
      cycle(1'b0);
    end
    ld_valid_i = 1'b0;
    check("d_pending", 512'(pending_o), 512'(1));
    kernel_sel_i = 2'd1;
    cycle(1'b1);

    // Final beat on a frame start: commit waits for the next frame start.
    start_load(2'd0);
    beats(LIN - 1);
    ld_valid_i = 1'b1; ld_data_i = FPW'($urandom); kernel_sel_i = 2'd0;
    cycle(1'b1);
    ld_valid_i = 1'b0;
    check("e_still_pending", 512'(pending_o), 512'(1));
    check("e_no_commit",     512'(kernel_o),  512'(id_flat));
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    check("e_committed", 512'(pending_o), 512'(0));

    // Selection change in the middle of a frame is deferred.
    snap = bank_flat(m_sel);
    kernel_sel_i = 2'd2;
    set_pixel(1'b0);
    valid_i = 1'b1; col_i = 16'd7; row_i = 16'd3;
    step();
    check("f_sel_hold", 512'(kernel_o), 512'(snap));
    cycle(1'b0);
    cycle(1'b1);
    check("f_sel_new", 512'(kernel_o), 512'({LIN{16'h3C00}}));

    // Reset in the middle of a load discards it.
    start_load(2'd1);
    beats(10);
    rst_i = 1'b1;
    cycle(1'b0);
    rst_i = 1'b0;
    check("g_ready",   512'(ld_ready_o), 512'(0));
    check("g_pending", 512'(pending_o),  512'(0));
    ld_valid_i = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    ld_valid_i = 1'b0;
    kernel_sel_i = 2'd1;
    cycle(1'b1);
    check("g_bank_identity", 512'(kernel_o), 512'(id_flat));

    // Free-running random traffic, including out-of-range bank indices.
    for (int n = 0; n < 1500; n++) begin
      rst_i        = ($urandom_range(0, 499) == 0);
      ld_start_i   = ($urandom_range(0, 19) == 0);
      ld_kernel_i  = KW'($urandom);
      ld_valid_i   = 1'($urandom);
      ld_data_i    = FPW'($urandom);
      kernel_sel_i = KW'($urandom);
      cycle($urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_fp_kernel_bank.md
CONV_FP_KERNEL_BANK -- requirements
Module: conv_fp_kernel_bank

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, floating-point exponent width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, floating-point fraction width.
REQ-003 SHALL have parameter WINDOW_WIDTH, default 5, kernel/window columns.
REQ-004 SHALL have parameter WINDOW_HEIGHT, default 5, kernel/window rows.
REQ-005 SHALL have parameter NUM_KERNELS, default 4, number of runtime-loadable kernel banks (>=1).
REQ-006 SHALL define FP_WIDTH = 1+EXP_WIDTH+FRAC_WIDTH, LINEAR = WINDOW_WIDTH*WINDOW_HEIGHT and KSEL_W = max(1,$clog2(NUM_KERNELS)).
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (clock) and rst_i input 1 (synchronous active-high reset).
REQ-008 SHALL have ports window_i input [FP_WIDTH][H][W] (pixel window), col_i input 16, row_i input 16 and valid_i input 1.
REQ-009 SHALL have port kernel_sel_i input KSEL_W, the active bank to use for the next frame.
REQ-010 SHALL have load ports ld_start_i input 1, ld_kernel_i input KSEL_W, ld_valid_i input 1, ld_data_i input FP_WIDTH and ld_ready_o output 1.
REQ-011 SHALL have outputs window_o [FP_WIDTH][H][W], kernel_o [FP_WIDTH][H][W], col_o 16, row_o 16, valid_o 1, pending_o 1 (commit waiting).

Function
REQ-012 SHALL hold NUM_KERNELS active kernels plus one shadow kernel and one shadow target index.
REQ-013 SHALL register window_i, col_i, row_i and valid_i to their outputs with exactly 1-cycle latency; kernel_o aligns with the same cycle.
REQ-014 SHALL define frame start as valid_i=1 with col_i=0 and row_i=0.
REQ-015 SHALL run a load FSM with states IDLE, LOAD and PENDING.
REQ-016 SHALL, in IDLE with ld_start_i=1, latch ld_kernel_i as target, clear the beat counter and enter LOAD; ld_start_i in other states is ignored.
REQ-017 SHALL drive ld_ready_o=1 only in LOAD; each beat with ld_valid_i=1 writes ld_data_i to shadow[idx] in raster order (idx = row*WINDOW_WIDTH+col) and increments idx.
REQ-018 SHALL enter PENDING after beat LINEAR-1 is accepted, with pending_o=1 while in PENDING.
REQ-019 SHALL, in PENDING on a frame-start cycle, copy shadow into active[target] and return to IDLE.
REQ-020 SHALL not commit if the final load beat and a frame start coincide; the commit occurs at the next frame start.
REQ-021 SHALL sample kernel_sel_i only on frame-start cycles; kernel_o then holds active[sel] until the next frame start.
REQ-022 SHALL make a same-cycle commit visible: the output cycle after a committing frame start shows the post-commit kernel when sel equals target.
REQ-023 SHALL treat kernel_sel_i >= NUM_KERNELS or ld_kernel_i >= NUM_KERNELS as index 0.
REQ-024 SHALL leave valid_o=0 cycles' window_o/col_o/row_o as registered input values (no gating required).

Reset
REQ-025 SHALL, on rst_i=1, set valid_o=0, col_o=0, row_o=0, window_o all 0, ld_ready_o=0, pending_o=0, FSM=IDLE, idx=0 and selected bank=0.
REQ-026 SHALL, on reset, load every active kernel with identity: centre entry (row H/2, col W/2) = 1.0 (sign 0, exponent 2^(EXP_WIDTH-1)-1, fraction 0; 16'h3C00 at defaults), all others 0; shadow cleared to 0.
REQ-027 SHALL, on reset mid-LOAD or mid-PENDING, discard the partial/pending load and drive kernel_o as identity from the following cycle.

Verification
REQ-028 SHALL cover: reset, then valid_i=1 col=0 row=0 -> next cycle valid_o=1 and kernel_o[2][2]=16'h3C00 with all other entries 0.
REQ-029 SHALL cover: ld_start kernel=2 and 25 beats of 16'h3C00 with sel=2 at the next frame start -> pending_o=1 until the frame start; the following cycle all 25 kernel_o entries are 16'h3C00.
REQ-030 SHALL cover: ld_valid_i toggling 0/1 during LOAD -> only accepted beats advance idx; exactly 25 accepted beats reach PENDING.
REQ-031 SHALL cover: last beat coinciding with a frame start -> no commit; pending_o stays 1 and the commit happens at the next frame start.
REQ-032 SHALL cover: kernel_sel_i changed mid-frame (col=7, row=3) -> kernel_o unchanged until the next frame start.
REQ-033 SHALL cover: rst_i asserted after 10 load beats -> ld_ready_o=0, pending_o=0 and the bank unmodified at the next commit attempt.
